// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and pipelined control outputs of ctrl_pipe.
// FORWARD_EN adds the fwd_a/fwd_b operand-select outputs.
interface ctrl_pipe_if #(
   parameter int OPW    = 6,
   parameter int REGW   = 5,
   parameter int ALUOPW = 3,
   parameter int CNTW   = 16
);
   logic              id_valid;
   logic [OPW-1:0]    id_opcode;
   logic [REGW-1:0]   id_rs;
   logic [REGW-1:0]   id_rt;
   logic [REGW-1:0]   id_rd;
   logic              br_taken;
   logic              stall;
   logic              flush_ifid;
   logic              ex_alusrc;
   logic [ALUOPW-1:0] ex_aluop;
   logic              ex_branch;
   logic              mem_read;
   logic              mem_write;
   logic              wb_wen;
   logic              wb_memtoreg;
   logic [REGW-1:0]   wb_wreg;
   logic [CNTW-1:0]   stall_cnt;
`ifdef FORWARD_EN
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
`endif

   modport master (
      output id_valid, id_opcode,
      output id_rs, id_rt, id_rd,
      output br_taken,
      input  stall, flush_ifid,
      input  ex_alusrc, ex_aluop,
      input  ex_branch,
      input  mem_read, mem_write,
      input  wb_wen, wb_memtoreg,
      input  wb_wreg, stall_cnt
`ifdef FORWARD_EN
     ,input  fwd_a, fwd_b
`endif
   );

   modport slave (
      input  id_valid, id_opcode,
      input  id_rs, id_rt, id_rd,
      input  br_taken,
      output stall, flush_ifid,
      output ex_alusrc, ex_aluop,
      output ex_branch,
      output mem_read, mem_write,
      output wb_wen, wb_memtoreg,
      output wb_wreg, stall_cnt
`ifdef FORWARD_EN
     ,output fwd_a, fwd_b
`endif
   );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control regs,
// RAW/load-use stall and branch flush. FORWARD_EN enables forwarding.
module ctrl_pipe #(
   parameter int OPW    = 6,
   parameter int REGW   = 5,
   parameter int ALUOPW = 3,
   parameter int CNTW   = 16
) (
   input logic         clk,
   input logic         rst,
   ctrl_pipe_if.slave  bus
);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h00);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h01);
   localparam logic [OPW-1:0] OP_AND  = OPW'(6'h02);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h03);
   localparam logic [OPW-1:0] OP_COM  = OPW'(6'h04);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h05);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h08);
   localparam logic [OPW-1:0] OP_LW   = OPW'(6'h10);
   localparam logic [OPW-1:0] OP_SW   = OPW'(6'h11);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h12);

   typedef struct packed {
`ifdef FORWARD_EN
      logic [REGW-1:0]   rs;
      logic [REGW-1:0]   rt;
`endif
      logic [REGW-1:0]   wreg;
      logic              wen;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              branch;
      logic              alusrc;
      logic [ALUOPW-1:0] aluop;
   } id_ex_t;

   typedef struct packed {
      logic [REGW-1:0] wreg;
      logic            wen;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
   } ex_mem_t;

   typedef struct packed {
      logic [REGW-1:0] wreg;
      logic            wen;
      logic            memtoreg;
   } mem_wb_t;

   id_ex_t  dec;
   id_ex_t  id_ex;
   ex_mem_t ex_mem;
   mem_wb_t mem_wb;

   logic [CNTW-1:0] cnt_q;
   logic            use_rs;
   logic            use_rt;
   logic            is_rr;
   logic            is_com;
   logic            is_addi;
   logic            is_lw;
   logic            is_sw;
   logic            is_beq;
   logic            ex_hit;
   logic            raw;
   logic            flush;
   logic            stall;

   logic [OPW-1:0] op;
   assign op = bus.id_opcode;

   assign is_rr   = (op == OP_ADD) | (op == OP_SUB) |
                    (op == OP_AND) | (op == OP_XOR) |
                    (op == OP_MUL);
   assign is_com  = (op == OP_COM);
   assign is_addi = (op == OP_ADDI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_beq  = (op == OP_BEQ);

   always_comb begin
      dec    = '0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      if (bus.id_valid) begin
         unique case (1'b1)
            is_rr: begin
               dec.wen      = 1'b1;
               dec.memtoreg = 1'b1;
               dec.aluop    = op[ALUOPW-1:0];
               dec.wreg     = bus.id_rd;
               use_rs       = 1'b1;
               use_rt       = 1'b1;
            end
            is_com: begin
               dec.wen      = 1'b1;
               dec.memtoreg = 1'b1;
               dec.aluop    = op[ALUOPW-1:0];
               dec.wreg     = bus.id_rd;
               use_rs       = 1'b1;
            end
            is_addi: begin
               dec.wen      = 1'b1;
               dec.memtoreg = 1'b1;
               dec.alusrc   = 1'b1;
               dec.aluop    = op[ALUOPW-1:0];
               dec.wreg     = bus.id_rt;
               use_rs       = 1'b1;
            end
            is_lw: begin
               dec.wen      = 1'b1;
               dec.memread  = 1'b1;
               dec.alusrc   = 1'b1;
               dec.wreg     = bus.id_rt;
               use_rs       = 1'b1;
            end
            is_sw: begin
               dec.memwrite = 1'b1;
               dec.alusrc   = 1'b1;
               use_rs       = 1'b1;
               use_rt       = 1'b1;
            end
            is_beq: begin
               dec.branch   = 1'b1;
               dec.aluop    = ALUOPW'(1);
               use_rs       = 1'b1;
               use_rt       = 1'b1;
            end
            default: ;
         endcase
      end
`ifdef FORWARD_EN
      if (use_rs) begin
         dec.rs = bus.id_rs;
         dec.rt = bus.id_rt;
      end
`endif
      // r0 is hardwired, never write it
      if (dec.wreg == '0) dec.wen = 1'b0;
   end

   assign ex_hit = (id_ex.wreg != '0) &&
                   ((use_rs && id_ex.wreg == bus.id_rs) ||
                    (use_rt && id_ex.wreg == bus.id_rt));

`ifdef FORWARD_EN
   assign raw = id_ex.memread & ex_hit;
`else
   logic mem_hit;
   assign mem_hit = (ex_mem.wreg != '0) &&
                    ((use_rs && ex_mem.wreg == bus.id_rs) ||
                     (use_rt && ex_mem.wreg == bus.id_rt));
   assign raw = (id_ex.wen & ex_hit) |
                (ex_mem.wen & mem_hit);
`endif

   // taken branch kills the ID instruction, so its hazard is moot
   assign flush = ~rst & bus.br_taken & id_ex.branch;
   assign stall = ~rst & raw & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex  <= '0;
         ex_mem <= '0;
         mem_wb <= '0;
         cnt_q  <= '0;
      end else begin
         id_ex           <= (stall | flush) ? '0 : dec;
         ex_mem.wreg     <= id_ex.wreg;
         ex_mem.wen      <= id_ex.wen;
         ex_mem.memread  <= id_ex.memread;
         ex_mem.memwrite <= id_ex.memwrite;
         ex_mem.memtoreg <= id_ex.memtoreg;
         mem_wb.wreg     <= ex_mem.wreg;
         mem_wb.wen      <= ex_mem.wen;
         mem_wb.memtoreg <= ex_mem.memtoreg;
         if (stall && cnt_q != '1)
            cnt_q <= cnt_q + CNTW'(1);
      end
   end

`ifdef FORWARD_EN
   logic [1:0] fa;
   logic [1:0] fb;

   always_comb begin
      fa = 2'b00;
      fb = 2'b00;
      if (ex_mem.wen && ex_mem.wreg != '0 &&
          ex_mem.wreg == id_ex.rs)
         fa = 2'b10;
      else if (mem_wb.wen && mem_wb.wreg == id_ex.rs)
         fa = 2'b01;
      if (ex_mem.wen && ex_mem.wreg != '0 &&
          ex_mem.wreg == id_ex.rt)
         fb = 2'b10;
      else if (mem_wb.wen && mem_wb.wreg == id_ex.rt)
         fb = 2'b01;
   end

   assign bus.fwd_a = fa;
   assign bus.fwd_b = fb;
`endif

   assign bus.stall       = stall;
   assign bus.flush_ifid  = flush;
   assign bus.ex_alusrc   = id_ex.alusrc;
   assign bus.ex_aluop    = id_ex.aluop;
   assign bus.ex_branch   = id_ex.branch;
   assign bus.mem_read    = ex_mem.memread;
   assign bus.mem_write   = ex_mem.memwrite;
   assign bus.wb_wen      = mem_wb.wen;
   assign bus.wb_memtoreg = mem_wb.memtoreg;
   assign bus.wb_wreg     = mem_wb.wreg;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: instruction-level model plus directed scenarios.
// Works with and without FORWARD_EN.
module tb_ctrl_pipe;

   localparam logic [5:0] ADD  = 6'h00;
   localparam logic [5:0] SUB  = 6'h01;
   localparam logic [5:0] XOR_ = 6'h03;
   localparam logic [5:0] COM  = 6'h04;
   localparam logic [5:0] MUL  = 6'h05;
   localparam logic [5:0] ADDI = 6'h08;
   localparam logic [5:0] LW   = 6'h10;
   localparam logic [5:0] SW   = 6'h11;
   localparam logic [5:0] BEQ  = 6'h12;
   localparam logic [5:0] BAD  = 6'h3f;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipe_if bus();

   ctrl_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   function automatic void chk(string nm,
                               logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t",
                    nm, act, exp, $time);
   endfunction

   typedef struct packed {
      logic       v;
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } ins_t;

   // what one instruction means, straight from the opcode table
   typedef struct packed {
      logic       wen;
      logic       alusrc;
      logic [2:0] aluop;
      logic       mrd;
      logic       mwr;
      logic       m2r;
      logic       br;
      logic [4:0] wreg;
      logic       urs;
      logic       urt;
      logic [4:0] rs;
      logic [4:0] rt;
   } ctl_t;

   function automatic ctl_t ctl(ins_t i);
      ctl_t c = '0;
      if (!i.v) return c;
      case (i.op)
         ADD, SUB, 6'h02, XOR_, MUL: begin
            c.wen = 1; c.m2r = 1; c.aluop = i.op[2:0];
            c.wreg = i.rd; c.urs = 1; c.urt = 1;
         end
         COM: begin
            c.wen = 1; c.m2r = 1; c.aluop = 3'd4;
            c.wreg = i.rd; c.urs = 1;
         end
         ADDI: begin
            c.wen = 1; c.m2r = 1; c.alusrc = 1;
            c.wreg = i.rt; c.urs = 1;
         end
         LW: begin
            c.wen = 1; c.mrd = 1; c.alusrc = 1;
            c.wreg = i.rt; c.urs = 1;
         end
         SW: begin
            c.mwr = 1; c.alusrc = 1; c.urs = 1; c.urt = 1;
         end
         BEQ: begin
            c.br = 1; c.aluop = 3'd1; c.urs = 1; c.urt = 1;
         end
         default: return c;
      endcase
      c.rs = i.rs;
      c.rt = i.rt;
      if (c.wreg == 0) c.wen = 0;
      return c;
   endfunction

   ctl_t m_ex = '0;
   ctl_t m_mem = '0;
   ctl_t m_wb = '0;
   logic [15:0] m_cnt = '0;
   bit m_last_stall = 1'b0;

   function automatic ctl_t cur_id();
      ins_t i;
      i = '{bus.id_valid, bus.id_opcode,
            bus.id_rs, bus.id_rt, bus.id_rd};
      return ctl(i);
   endfunction

   function automatic bit reads(ctl_t p, ctl_t d);
      return p.wreg != 0 &&
             ((d.urs && p.wreg == d.rs) ||
              (d.urt && p.wreg == d.rt));
   endfunction

   function automatic bit e_flush();
      return !rst && bus.br_taken && m_ex.br;
   endfunction

   function automatic bit e_stall();
      ctl_t d;
      bit h;
      d = cur_id();
`ifdef FORWARD_EN
      h = m_ex.mrd && reads(m_ex, d);
`else
      h = (m_ex.wen && reads(m_ex, d)) ||
          (m_mem.wen && reads(m_mem, d));
`endif
      return !rst && h && !e_flush();
   endfunction

`ifdef FORWARD_EN
   function automatic logic [1:0] e_fwd(logic [4:0] r);
      if (m_mem.wen && m_mem.wreg != 0 && m_mem.wreg == r)
         return 2'b10;
      if (m_wb.wen && m_wb.wreg == r) return 2'b01;
      return 2'b00;
   endfunction
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_ex <= '0;
         m_mem <= '0;
         m_wb <= '0;
         m_cnt <= '0;
         m_last_stall <= 1'b0;
      end else begin
         m_wb <= m_mem;
         m_mem <= m_ex;
         m_ex <= (e_stall() || e_flush()) ? '0 : cur_id();
         m_cnt <= (e_stall() && m_cnt != 16'hffff) ?
                  m_cnt + 16'd1 : m_cnt;
         m_last_stall <= e_stall();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", bus.stall, e_stall());
         chk("flush", bus.flush_ifid, e_flush());
         chk("ex_alusrc", bus.ex_alusrc, m_ex.alusrc);
         chk("ex_aluop", bus.ex_aluop, m_ex.aluop);
         chk("ex_branch", bus.ex_branch, m_ex.br);
         chk("mem_read", bus.mem_read, m_mem.mrd);
         chk("mem_write", bus.mem_write, m_mem.mwr);
         chk("wb_wen", bus.wb_wen, m_wb.wen);
         chk("wb_m2r", bus.wb_memtoreg, m_wb.m2r);
         chk("wb_wreg", bus.wb_wreg, m_wb.wreg);
         chk("stall_cnt", bus.stall_cnt, m_cnt);
`ifdef FORWARD_EN
         chk("fwd_a", bus.fwd_a, e_fwd(m_ex.rs));
         chk("fwd_b", bus.fwd_b, e_fwd(m_ex.rt));
`endif
      end
   end

   task automatic drv(logic v, logic [5:0] op,
                      logic [4:0] rs, logic [4:0] rt,
                      logic [4:0] rd, logic br);
      bus.id_valid  = v;
      bus.id_opcode = op;
      bus.id_rs     = rs;
      bus.id_rt     = rt;
      bus.id_rd     = rd;
      bus.br_taken  = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one instruction and hold it while the pipe stalls
   task automatic issue(logic [5:0] op, logic [4:0] rs,
                        logic [4:0] rt, logic [4:0] rd);
      int guard = 0;
      drv(1, op, rs, rt, rd, 0);
      tick();
      while (m_last_stall && guard < 8) begin
         tick();
         guard++;
      end
      if (m_last_stall) chk("stall_bound", m_last_stall, 0);
   endtask

   task automatic idle(int n);
      drv(0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drv(1, ADD, 1, 2, 3, 0);
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_cnt", bus.stall_cnt, 0);
      chk("rst_wb_wen", bus.wb_wen, 0);
      chk("rst_wb_wreg", bus.wb_wreg, 0);
      chk("rst_stall", bus.stall, 0);
      tick();
      rst = 1'b0;

      // ADD r3,r1,r2 held through reset
      tick();
      chk("add_ex_aluop", bus.ex_aluop, 3'b000);
      chk("add_ex_alusrc", bus.ex_alusrc, 0);
      drv(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("add_wb_wen", bus.wb_wen, 1);
      chk("add_wb_wreg", bus.wb_wreg, 3);
      chk("add_wb_m2r", bus.wb_memtoreg, 1);

      issue(SUB, 1, 2, 7);
      chk("sub_ex_aluop", bus.ex_aluop, 3'b001);
      issue(ADDI, 1, 0, 9);
      chk("addi_ex_alusrc", bus.ex_alusrc, 1);
      issue(BAD, 1, 2, 3);
      chk("bad_ex_alusrc", bus.ex_alusrc, 0);
      idle(1);
      chk("addi_r0_wen", bus.wb_wen, 0);
      chk("bad_mem_write", bus.mem_write, 0);

      issue(COM, 3, 9, 10);
      issue(MUL, 10, 10, 11);
      issue(SW, 1, 11, 0);
      issue(XOR_, 11, 10, 12);
      issue(BEQ, 12, 12, 0);
      issue(LW, 12, 13, 0);
      issue(ADD, 13, 12, 14);

      // load-use, reset discards the in-flight work above
      do_reset();
      chk("rst2_cnt", bus.stall_cnt, 0);
      drv(1, LW, 1, 4, 0, 0);
      tick();
      drv(1, ADD, 4, 1, 5, 0);
      #2;
      chk("lu_stall", bus.stall, 1);
      tick();
`ifdef FORWARD_EN
      chk("lu_stall_end", bus.stall, 0);
      chk("lu_cnt", bus.stall_cnt, 1);
      chk("lu_bubble_alusrc", bus.ex_alusrc, 0);
      chk("lu_mem_read", bus.mem_read, 1);
      tick();
      chk("lu_fwd_a", bus.fwd_a, 2'b01);
      chk("lu_fwd_b", bus.fwd_b, 2'b00);
      chk("lu_wb_wreg", bus.wb_wreg, 4);
      chk("lu_wb_m2r", bus.wb_memtoreg, 0);
`else
      chk("lu_stall2", bus.stall, 1);
      tick();
      chk("lu_stall_end", bus.stall, 0);
      chk("lu_cnt", bus.stall_cnt, 2);
      tick();
      chk("lu_add_in_ex", bus.ex_alusrc, 0);
`endif

      // ADD r3 then SUB r6,r3,r3
      do_reset();
      drv(1, ADD, 1, 2, 3, 0);
      tick();
      drv(1, SUB, 3, 3, 6, 0);
      #2;
`ifdef FORWARD_EN
      chk("raw_stall", bus.stall, 0);
      tick();
      chk("raw_sub_ex", bus.ex_aluop, 3'b001);
      chk("raw_fwd_a", bus.fwd_a, 2'b10);
      chk("raw_fwd_b", bus.fwd_b, 2'b10);
      chk("raw_cnt", bus.stall_cnt, 0);
`else
      chk("raw_stall1", bus.stall, 1);
      tick();
      chk("raw_stall2", bus.stall, 1);
      chk("raw_bubble", bus.ex_aluop, 3'b000);
      tick();
      chk("raw_stall_end", bus.stall, 0);
      tick();
      chk("raw_sub_ex", bus.ex_aluop, 3'b001);
      chk("raw_cnt", bus.stall_cnt, 2);
`endif

      // taken BEQ in EX beats a hazard in ID
      do_reset();
      drv(1, LW, 1, 3, 0, 0);
      tick();
      drv(1, BEQ, 1, 2, 0, 0);
      tick();
      chk("beq_ex_branch", bus.ex_branch, 1);
      drv(1, SUB, 3, 3, 6, 1);
      #2;
      chk("fl_flush", bus.flush_ifid, 1);
      chk("fl_stall", bus.stall, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("fl_ex_branch", bus.ex_branch, 0);
      chk("fl_ex_aluop", bus.ex_aluop, 3'b000);
      chk("fl_cnt", bus.stall_cnt, 0);
      issue(BEQ, 5, 5, 0);
      drv(1, ADD, 7, 8, 9, 0);
      #2;
      chk("nt_flush", bus.flush_ifid, 0);
      tick();
      chk("nt_add_ex", bus.ex_branch, 0);
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Pipelined successor to the single-cycle control decoder. It decodes the ID-stage opcode and registers the control bundle through the ID/EX, EX/MEM and MEM/WB stages. It also detects load-use and RAW hazards and handles taken-branch flush. It sits beside the 5-stage datapath and drives the ALU, memory, register-file write-back and PC/IF-ID hold/flush controls.

Parameters:
OPW, 6, opcode width; opcodes come from define.v macros.
REGW, 5, register address width.
ALUOPW, 3, ALU op width; ALU ops use opcode[ALUOPW-1:0].
CNTW, 16, stall-counter width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  OPW  opcode in ID
id_rs  in  REGW  source register A in ID
id_rt  in  REGW  source register B / I-type destination in ID
id_rd  in  REGW  R-type destination in ID
br_taken  in  1  EX-stage compare equal; meaningful only when EX holds BEQ
stall  out  1  hold PC and IF/ID (combinational)
flush_ifid  out  1  clear IF/ID (combinational)
ex_alusrc  out  1  ALU operand B = immediate
ex_aluop  out  ALUOPW  ALU operation
ex_branch  out  1  EX holds BEQ
mem_read  out  1  data memory read
mem_write  out  1  data memory write
wb_wen  out  1  register-file write enable
wb_memtoreg  out  1  1 = ALU result, 0 = memory data
wb_wreg  out  REGW  write-back register address
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Decode (combinational, ID stage):
  - ADD/SUB/AND/XOR/COM/MUL: wen=1, alusrc=0, aluop=opcode[2:0], wreg=rd.
  - ADDI: wen=1, alusrc=1, aluop=opcode[2:0], wreg=rt.
  - LW: wen=1, memread=1, memtoreg=0, alusrc=1, aluop=000, wreg=rt.
  - SW: memwrite=1, alusrc=1, aluop=000.
  - BEQ: branch=1, aluop=001.
  - Unknown opcode or id_valid=0: bubble (all enables 0).
- Write enable is forced to 0 when wreg==0, so r0 is never written.
- Source use: rs is used by all except unknown. rt is used by ADD, SUB, AND, XOR, MUL, SW, BEQ. COM reads rs only.
- Latency: ID instruction's controls appear on ex_* 1 cycle later, mem_* 2 cycles, wb_* 3 cycles. EX/MEM and MEM/WB always advance.
- ID/EX register also holds rs, rt, wreg, wen, memread, memwrite, memtoreg and branch.
- Load-use hazard: ID/EX memread=1 and wreg!=0, and that wreg matches a used ID source → stall=1. ID/EX then loads a bubble and the ID instruction is re-presented next cycle.
- Flush: br_taken & ex_branch → flush_ifid=1 and ID/EX loads a bubble. Flush has priority: stall is forced to 0 in that cycle.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Reset: all stage registers hold bubbles; every output is 0, including wb_wreg and stall_cnt. Reset asserted mid-operation discards in-flight control on the next edge.
- Register-file writes occur before reads in the same cycle, so a producer in WB never causes a stall.

Optional Feature:
Macro FORWARD_EN.
- Defined: adds outputs fwd_a and fwd_b (2 bits each) for EX operands rs/rt.
  - 10 when MEM-stage wen=1, wreg!=0 and wreg matches.
  - Otherwise 01 when WB-stage wen=1 and wreg matches.
  - Otherwise 00.
  - MEM has priority over WB. Only load-use stalls.
- Undefined: no fwd ports. stall=1 whenever the EX or MEM stage has wen=1, wreg!=0, and wreg matches a used ID source.

Test Plan:
- rst=1 for 2 cycles with id_valid=1 ADD → all outputs 0, stall_cnt=0; first ADD controls on ex_* 1 cycle after rst falls.
- ADD r3,r1,r2 → next cycle ex_aluop=ADD[2:0], ex_alusrc=0; 3 cycles after issue wb_wen=1, wb_wreg=3, wb_memtoreg=1.
- LW r4 then ADD r5,r4,r1 (FORWARD_EN) → stall=1 for exactly 1 cycle with an EX bubble; stall_cnt=1; ADD in EX gets fwd_a=01.
- BEQ in EX with br_taken=1 while ID has a load-use hazard → flush_ifid=1, stall=0, ex_* bubble next cycle.
- ADDI r0,r1,5 → wb_wen=0 at WB; unknown opcode → no enables set at any stage.
- ADD r3 then SUB r6,r3,r3 (no FORWARD_EN) → stall=1 for 2 cycles, stall_cnt=2, SUB reaches EX 3 cycles after issue.
